// File: rtl/mdu_multicycle.sv
// mdu_multicycle: multi-cycle multiply/divide unit with architectural HI/LO.
//   Sits beside the EX-stage ALU. MULT/MULTU (and, when enabled, MADD/MSUB) take
//   MULT_CYCLES cycles and DIV/DIVU take DIV_CYCLES cycles. The pipeline stalls on
//   busy. MTHI/MTLO write HI/LO in one edge without raising busy.
// Optional feature macro: MDU_MADD_EN enables MADD (op 7) and MSUB (op 8).
//   When it is undefined, ops 7 and 8 are NOPs.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   start, op[3:0]   issue strobe and opcode, sampled on the rising edge
//   A, B             operands rs/rt, latched at issue
//   busy             high for exactly N cycles while an op is in flight
//   done             one-cycle pulse on the edge HI/LO take a mul/div result
//   hi, lo           architectural HI/LO registers
module mdu_multicycle #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
`endif

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_LAT = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          accept, commit, mt_hi, mt_lo;
  req_t          req;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    commit  = 1'b0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    case (state)
      IDLE: if (start) begin
        case (op)
          OP_MULT, OP_MULTU
`ifdef MDU_MADD_EN
          , OP_MADD, OP_MSUB
`endif
          : begin
            accept  = 1'b1;
            cnt_d   = MUL_LAT;
            state_d = RUN;
          end
          OP_DIV, OP_DIVU: begin
            accept  = 1'b1;
            cnt_d   = DIV_LAT;
            state_d = RUN;
          end
          OP_MTHI: mt_hi = 1'b1;
          OP_MTLO: mt_lo = 1'b1;
          default: ;
        endcase
      end
      // Any start seen here is dropped, including MTHI/MTLO; this holds on the
      // commit edge too, so the earliest re-issue is the edge after commit.
      RUN: begin
        if (cnt == '0) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // ---------------------------------------------------------------- datapath
  logic [2*WIDTH-1:0] a_sx, b_sx, prod_s, prod_u, res;
  logic               sdiv, a_neg, b_neg;
  logic [WIDTH-1:0]   dvd, dvs, uq, ur, q, r;

  always_comb begin
    a_sx   = {{WIDTH{req.a[WIDTH-1]}}, req.a};
    b_sx   = {{WIDTH{req.b[WIDTH-1]}}, req.b};
    // The low 2*WIDTH bits of the sign-extended product are the signed product.
    prod_s = a_sx * b_sx;
    prod_u = {{WIDTH{1'b0}}, req.a} * {{WIDTH{1'b0}}, req.b};

    // A single unsigned divider on magnitudes serves both DIV and DIVU.
    // MIN/-1 falls out naturally: |MIN| = 2^(W-1), negated back to MIN, rem 0.
    sdiv  = (req.op == OP_DIV);
    a_neg = sdiv & req.a[WIDTH-1];
    b_neg = sdiv & req.b[WIDTH-1];
    dvd   = a_neg ? -req.a : req.a;
    dvs   = b_neg ? -req.b : req.b;
    uq    = '0;
    ur    = '0;
    if (req.b != '0) begin
      uq = dvd / dvs;
      ur = dvd % dvs;
    end
    q = (a_neg ^ b_neg) ? -uq : uq;
    r = a_neg ? -ur : ur;

    case (req.op)
      OP_MULT:          res = prod_s;
      OP_MULTU:         res = prod_u;
      OP_DIV, OP_DIVU:  res = (req.b == '0) ? {req.a, {WIDTH{1'b1}}} : {r, q};
`ifdef MDU_MADD_EN
      // HI/LO cannot change during busy, so the current value equals the one at issue.
      OP_MADD:          res = {hi, lo} + prod_s;
      OP_MSUB:          res = {hi, lo} - prod_s;
`endif
      default:          res = {hi, lo};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req  <= '0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      done <= commit;
      if (accept) req <= '{op: op, a: A, b: B};
      if (commit) begin
        {hi, lo} <= res;
      end else begin
        if (mt_hi) hi <= A;
        if (mt_lo) lo <= A;
      end
    end
  end
endmodule

// File: tb/tb_mdu_multicycle.sv
// Bench for mdu_multicycle at default parameters. A behavioural model computes
// each result at issue time with plain integer arithmetic and releases it after
// the op latency. A negedge process compares busy/done/hi/lo every cycle, and
// directed vectors pin the model with hand-computed literals.
module tb_mdu_multicycle;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   op;
  logic [W-1:0] A, B, hi, lo;
  logic         busy, done;

  int n_pass = 0;
  int n_chk  = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mdu_multicycle #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ------------------------------------------------------------ model
  function automatic int lat(input logic [3:0] o);
    case (o)
      4'd1, 4'd2: return MC;
      4'd3, 4'd4: return DC;
`ifdef MDU_MADD_EN
      4'd7, 4'd8: return MC;
`endif
      default:    return 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_op(input logic [3:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
    longint          sp;
    longint unsigned up;
    int              sq, sr;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    case (o)
      4'd1: return sp;
      4'd2: return up;
      4'd3: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      4'd4: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      4'd7: return acc + sp;
      4'd8: return acc - sp;
      default: return acc;
    endcase
  endfunction

  int           m_rem;
  logic [W-1:0] m_hi, m_lo;
  logic [63:0]  m_pend;
  bit           m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          {m_hi, m_lo} <= m_pend;
          m_done       <= 1'b1;
        end
      end else if (start) begin
        if (lat(op) > 0) begin
          m_rem  <= lat(op);
          m_pend <= ref_op(op, A, B, {m_hi, m_lo});
        end else if (op == 4'd5) m_hi <= A;
        else if (op == 4'd6) m_lo <= A;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, m_rem > 0);
      chk("done", done, m_done);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  // ------------------------------------------------------------ stimulus
  // Caller sits 1 time unit after a rising edge.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int n, input string name);
    int c;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom;
    c = 0;
    while (busy && c < 100) begin
      c++;
      @(posedge clk); #1;
    end
    chk({name, " busy_cycles"}, c, n);
    chk({name, " done"}, done, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 100) begin
      c++;
      @(posedge clk); #1;
    end
    chk({name, " idle"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    run_op(4'd1, 32'hFFFFFFFE, 32'd3, MC, "mult");
    chk("mult hi", hi, 32'hFFFFFFFF);
    chk("mult lo", lo, 32'hFFFFFFFA);
    run_op(4'd2, 32'hFFFFFFFE, 32'd3, MC, "multu");
    chk("multu hi", hi, 32'h00000002);
    chk("multu lo", lo, 32'hFFFFFFFA);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, DC, "div");
    chk("div lo", lo, 32'hFFFFFFFD);
    chk("div hi", hi, 32'hFFFFFFFF);
    run_op(4'd4, 32'd7, 32'd0, DC, "divu0");
    chk("divu0 lo", lo, 32'hFFFFFFFF);
    chk("divu0 hi", hi, 32'd7);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, DC, "divovf");
    chk("divovf lo", lo, 32'h80000000);
    chk("divovf hi", hi, 32'h0);
    run_op(4'd3, 32'd7, 32'hFFFFFFFE, DC, "div_neg_divisor");
    chk("div7/-2 lo", lo, 32'hFFFFFFFD);
    chk("div7/-2 hi", hi, 32'd1);
    run_op(4'd3, 32'hFFFFFFF9, 32'd0, DC, "sdiv0");
    run_op(4'd1, 32'h7FFFFFFF, 32'h80000000, MC, "mult_ext");
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, MC, "multu_max");
    chk("multu_max hi", hi, 32'hFFFFFFFE);
    chk("multu_max lo", lo, 32'h00000001);

    // Busy protection: MTHI and MULT issued mid-DIVU must be dropped.
    start = 1'b1; op = 4'd4; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1; op = 4'd5; A = 32'h1234;
    @(posedge clk); #1;
    op = 4'd1; A = 32'd5; B = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("busyprot");
    chk("busyprot hi", hi, 32'd2);
    chk("busyprot lo", lo, 32'd14);

    // MTHI then MTLO back to back.
    start = 1'b1; op = 4'd5; A = 32'hAAAA;
    @(posedge clk); #1;
    chk("mthi hi", hi, 32'hAAAA);
    chk("mthi busy", busy, 1'b0);
    op = 4'd6; A = 32'h5555;
    @(posedge clk); #1;
    chk("mtlo lo", lo, 32'h5555);
    chk("mtlo busy", busy, 1'b0);
    chk("mtlo done", done, 1'b0);

    // MADD: hi=0, lo=all ones, + 1*1.
    op = 4'd5; A = 32'h0;
    @(posedge clk); #1;
    op = 4'd6; A = 32'hFFFFFFFF;
    @(posedge clk); #1;
    op = 4'd7; A = 32'd1; B = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef MDU_MADD_EN
    chk("madd busy", busy, 1'b1);
    wait_idle("madd");
    chk("madd hi", hi, 32'd1);
    chk("madd lo", lo, 32'd0);
`else
    chk("madd nop busy", busy, 1'b0);
    wait_idle("madd");
    chk("madd nop hi", hi, 32'd0);
    chk("madd nop lo", lo, 32'hFFFFFFFF);
`endif

    // Async reset in the middle of a DIV: nothing may commit afterwards.
    start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    chk("arst busy", busy, 1'b0);
    chk("arst done", done, 1'b0);
    chk("arst hi", hi, 32'h0);
    chk("arst lo", lo, 32'h0);
    @(negedge clk); #3 reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("post-rst busy", busy, 1'b0);
    chk("post-rst hi", hi, 32'h0);
    chk("post-rst lo", lo, 32'h0);

    run_op(4'd2, 32'd6, 32'd7, MC, "post-rst multu");
    chk("post-rst multu lo", lo, 32'd42);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
